// File: rtl/display_mux_7seg_pkg.sv
`default_nettype none
// ============================================================================
// display_pkg : segment patterns, anode constants and divider helper shared by
//               the display blocks.
// Rev 1.0
// ============================================================================
package display_pkg;

   // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [3:0] AN_OFF    = 4'b1111;

   function automatic int calc_div(input int clk_hz, input int refresh_hz);
      return clk_hz / refresh_hz;
   endfunction

endpackage
`default_nettype wire

// File: rtl/display_mux_7seg_if.sv
`default_nettype none
// ============================================================================
// display_mux_7seg_if : digit-select / segment bus between the display mux
//                       (master) and the BCD stage plus pads (slave).
// Rev 1.0
// ============================================================================
interface display_mux_7seg_if;

   logic       en;
   logic [3:0] digito;
   logic [1:0] sel;
   logic       tick;
   logic [3:0] an;
   logic [6:0] seg;

   modport master (
      input  en,
      input  digito,
      output sel,
      output tick,
      output an,
      output seg
   );

   modport slave (
      output en,
      output digito,
      input  sel,
      input  tick,
      input  an,
      input  seg
   );

endinterface
`default_nettype wire

// File: rtl/display_mux_7seg_decode.sv
`default_nettype none
// ============================================================================
// seg7_decode : combinational 4-bit digit to active-low 7-segment pattern.
// Rev 1.0
// ============================================================================
module seg7_decode
   import display_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/display_mux_7seg.sv
`default_nettype none
// ============================================================================
// display_mux_7seg : time-multiplexed common-anode 7-segment driver with
//                    refresh prescaler, digit-select counter and registered
//                    outputs. Optional anti-ghosting blank: DISPLAY_MUX_BLANK_EN.
// Rev 1.0
// ============================================================================
module display_mux_7seg
   import display_pkg::*;
#(
   parameter int CLK_HZ       = 100000000,
   parameter int REFRESH_HZ   = 10000,
   parameter int N_DIGITS     = 2,
   parameter int BLANK_CYCLES = 100
)(
   input  logic                  clk,
   input  logic                  rst,
   display_mux_7seg_if.master    bus
);

   localparam int             DIV       = calc_div(CLK_HZ, REFRESH_HZ);
   localparam int             PW        = (DIV < 2) ? 1 : $clog2(DIV);
   localparam logic [PW-1:0]  PRESC_MAX = PW'(DIV - 1);
   localparam logic [1:0]     SEL_MAX   = 2'(N_DIGITS - 1);

   if (DIV < 2) begin : g_chk_div
      $error("display_mux_7seg: CLK_HZ/REFRESH_HZ must be >= 2");
   end
   if (N_DIGITS < 1 || N_DIGITS > 4) begin : g_chk_digits
      $error("display_mux_7seg: N_DIGITS must be 1..4");
   end
   if (BLANK_CYCLES < 0 || BLANK_CYCLES >= DIV) begin : g_chk_blank
      $error("display_mux_7seg: BLANK_CYCLES must be below the refresh divider");
   end

   logic [PW-1:0] presc_q, presc_d;
   logic          tick_q,  tick_d;
   logic [1:0]    sel_q,   sel_d;
   logic [3:0]    an_q,    an_d;
   logic [6:0]    seg_q,   seg_d;

   logic [6:0]    dec_seg;
   logic [3:0]    pos_mask;
   logic [3:0]    sel_onehot;

   seg7_decode u_decode (
      .digit (bus.digito),
      .seg   (dec_seg)
   );

   // Positions beyond N_DIGITS can never light, whatever sel holds
   for (genvar i = 0; i < 4; i++) begin : g_pos_mask
      assign pos_mask[i] = (i < N_DIGITS);
   end

   assign sel_onehot = 4'b0001 << sel_q;

`ifdef DISPLAY_MUX_BLANK_EN
   localparam int            BW        = (BLANK_CYCLES < 1) ? 1 : $clog2(BLANK_CYCLES + 1);
   localparam logic [BW-1:0] BLANK_LEN = BW'(BLANK_CYCLES);

   logic [BW-1:0] blank_q, blank_d;
`endif

   always_comb begin
      presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
      tick_d  = (presc_q == PRESC_MAX);

      sel_d = sel_q;
      if (tick_q) begin
         sel_d = (sel_q == SEL_MAX) ? 2'd0 : sel_q + 2'd1;
      end

      // seg and an are both sampled from the current sel so they stay paired
      seg_d = dec_seg;
      an_d  = ~(sel_onehot & pos_mask);
      if (!bus.en) begin
         an_d = AN_OFF;
      end

`ifdef DISPLAY_MUX_BLANK_EN
      blank_d = blank_q;
      if (tick_q) begin
         blank_d = BLANK_LEN;
      end else if (blank_q != '0) begin
         blank_d = blank_q - BW'(1);
      end
      if (blank_q != '0) begin
         an_d = AN_OFF;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q <= '0;
         tick_q  <= 1'b0;
         sel_q   <= 2'd0;
         an_q    <= AN_OFF;
         seg_q   <= SEG_BLANK;
`ifdef DISPLAY_MUX_BLANK_EN
         blank_q <= '0;
`endif
      end else begin
         presc_q <= presc_d;
         tick_q  <= tick_d;
         sel_q   <= sel_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
`ifdef DISPLAY_MUX_BLANK_EN
         blank_q <= blank_d;
`endif
      end
   end

   assign bus.sel  = sel_q;
   assign bus.tick = tick_q;
   assign bus.an   = an_q;
   assign bus.seg  = seg_q;

endmodule
`default_nettype wire

// File: tb/tb_display_mux_7seg.sv
`default_nettype none
// ============================================================================
// tb_display_mux_7seg : self-checking bench, DIV=10, three instances with
//                       N_DIGITS = 2, 1 and 4.
// Rev 1.0
// ============================================================================
module tb_display_mux_7seg;

   localparam int TB_DIV   = 10;
   localparam int TB_BLANK = 3;
`ifdef DISPLAY_MUX_BLANK_EN
   localparam bit BLANK_ON = 1'b1;
`else
   localparam bit BLANK_ON = 1'b0;
`endif

   localparam logic [6:0] E_SEG3  = 7'b0110000;
   localparam logic [6:0] E_SEG1  = 7'b1111001;
   localparam logic [6:0] E_SEG8  = 7'b0000000;
   localparam logic [6:0] E_BLANK = 7'b1111111;

   typedef struct {
      logic [3:0] digit;
      logic [6:0] seg;
   } dec_vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ovr_en = 1'b0;
   logic [3:0] ovr_val = 4'd0;
   int         checks = 0;
   int         failures = 0;
   int         kc = 0;
   logic [6:0] sb[$];
   dec_vec_t   vec[16];

   always #5 clk = ~clk;

   display_mux_7seg_if bus2 ();
   display_mux_7seg_if bus1 ();
   display_mux_7seg_if bus4 ();

   // BCD stage model for bin = 13: units 3, tens 1
   assign bus2.digito = ovr_en ? ovr_val :
                        (bus2.sel == 2'd0) ? 4'd3 :
                        (bus2.sel == 2'd1) ? 4'd1 : 4'd0;
   assign bus1.digito = 4'd3;
   assign bus1.en     = 1'b1;
   assign bus4.digito = 4'd8;
   assign bus4.en     = 1'b1;

   display_mux_7seg #(.CLK_HZ(100), .REFRESH_HZ(10), .N_DIGITS(2), .BLANK_CYCLES(TB_BLANK))
      u_dut2 (.clk(clk), .rst(rst), .bus(bus2));
   display_mux_7seg #(.CLK_HZ(100), .REFRESH_HZ(10), .N_DIGITS(1), .BLANK_CYCLES(TB_BLANK))
      u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
   display_mux_7seg #(.CLK_HZ(100), .REFRESH_HZ(10), .N_DIGITS(4), .BLANK_CYCLES(TB_BLANK))
      u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s k=%0d got=%0h expected=%0h", name, kc, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Cycle k counts edges since reset release
   function automatic int sel_at(input int k, input int n);
      return (k < 1) ? 0 : ((k - 1) / TB_DIV) % n;
   endfunction

   function automatic logic tick_at(input int k);
      return (k > 0) && (k % TB_DIV == 0);
   endfunction

   function automatic logic [3:0] an_at(input int k, input int n, input bit en_ok);
      logic [3:0] one;
      one = 4'b0001;
      if (k < 1 || !en_ok) return 4'b1111;
      if (BLANK_ON && k >= TB_DIV + 2 && ((k - 2) % TB_DIV) < TB_BLANK) return 4'b1111;
      return ~(one << sel_at(k - 1, n));
   endfunction

   function automatic logic [6:0] seg2_at(input int k);
      if (k < 1) return E_BLANK;
      return (sel_at(k - 1, 2) == 0) ? E_SEG3 : E_SEG1;
   endfunction

   task automatic do_reset(input int cycles);
      bus2.en = 1'b1;
      rst = 1'b1;
      repeat (cycles) step();
      kc = 0;
      check("rst_an2",   32'(bus2.an),   32'(4'b1111));
      check("rst_seg2",  32'(bus2.seg),  32'(E_BLANK));
      check("rst_tick2", 32'(bus2.tick), 32'(1'b0));
      check("rst_sel2",  32'(bus2.sel),  32'(2'd0));
      check("rst_an1",   32'(bus1.an),   32'(4'b1111));
      check("rst_an4",   32'(bus4.an),   32'(4'b1111));
      rst = 1'b0;
   endtask

   task automatic run_scan(input int n, input int en_lo, input int en_hi);
      for (int k = 1; k <= n; k++) begin
         bit e;
         e = !(k >= en_lo && k <= en_hi);
         bus2.en = e;
         step();
         kc = k;
         check("tick2", 32'(bus2.tick), 32'(tick_at(k)));
         check("sel2",  32'(bus2.sel),  32'(sel_at(k, 2)));
         check("an2",   32'(bus2.an),   32'(an_at(k, 2, e)));
         check("seg2",  32'(bus2.seg),  32'(seg2_at(k)));
         check("tick1", 32'(bus1.tick), 32'(tick_at(k)));
         check("sel1",  32'(bus1.sel),  32'(2'd0));
         check("an1",   32'(bus1.an),   32'(an_at(k, 1, 1'b1)));
         check("seg1",  32'(bus1.seg),  32'(E_SEG3));
         check("sel4",  32'(bus4.sel),  32'(sel_at(k, 4)));
         check("an4",   32'(bus4.an),   32'(an_at(k, 4, 1'b1)));
         check("seg4",  32'(bus4.seg),  32'(E_SEG8));
      end
   endtask

   initial begin
      vec[0]  = '{4'd0,  7'b1000000};
      vec[1]  = '{4'd1,  7'b1111001};
      vec[2]  = '{4'd2,  7'b0100100};
      vec[3]  = '{4'd3,  7'b0110000};
      vec[4]  = '{4'd4,  7'b0011001};
      vec[5]  = '{4'd5,  7'b0010010};
      vec[6]  = '{4'd6,  7'b0000010};
      vec[7]  = '{4'd7,  7'b1111000};
      vec[8]  = '{4'd8,  7'b0000000};
      vec[9]  = '{4'd9,  7'b0010000};
      vec[10] = '{4'd12, 7'b1111111};
      vec[11] = '{4'd10, 7'b1111111};
      vec[12] = '{4'd15, 7'b1111111};
      vec[13] = '{4'd11, 7'b1111111};
      vec[14] = '{4'd13, 7'b1111111};
      vec[15] = '{4'd14, 7'b1111111};

      bus2.en = 1'b1;
      do_reset(3);
      // Full scan with en low for 25 cycles mid-run; ends 4 cycles after a tick
      run_scan(74, 26, 50);
      // Reset mid-scan, then confirm the first tick lands exactly DIV cycles later
      do_reset(1);
      run_scan(25, 0, -1);

      // Decoder table: expected pattern queued when the digit is driven
      ovr_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         logic [6:0] exp_seg;
         ovr_val = vec[i].digit;
         sb.push_back(vec[i].seg);
         step();
         kc = i;
         exp_seg = sb.pop_front();
         check("decode", 32'(bus2.seg), 32'(exp_seg));
      end
      ovr_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/display_mux_7seg.md
Name: display_mux_7seg

Overview:
- Time-multiplexed 7-segment driver directly downstream of the BCD digit-select stage.
- Generates the 10 kHz refresh tick and digit-select count that the BCD stage consumes.
- Takes back the 4-bit digit that stage returns for the selected position.
- Registers segment and anode patterns for the board's common-anode display (4 anodes, active-low).

Parameters:
- CLK_HZ, 100000000, system clock frequency.
- REFRESH_HZ, 10000, digit-advance rate; DIV = CLK_HZ/REFRESH_HZ, must be integer >= 2.
- N_DIGITS, 2, active display positions, legal 1..4; anodes with index >= N_DIGITS are always off.
- BLANK_CYCLES, 100, blanking length after each digit switch (used only with the optional feature); must be < DIV.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- en  input  1  display enable; 0 turns all anodes off, counters keep running
- digito  input  4  digit value for the current sel, returned combinationally by the BCD stage
- sel  output  2  current digit position (0 = units, 1 = tens, ...); drives the BCD stage's position input
- tick  output  1  one-cycle pulse at each refresh boundary
- an  output  4  anode enables, active-low
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low

Behaviour:
- One clock; reset is synchronous and active-high on rst, sampled at posedge clk. No asynchronous paths.
- Reset values:
  - prescaler = 0, sel = 0, tick = 0
  - an = 4'b1111, seg = 7'b1111111
  - blank counter = 0
- Prescaler:
  - Counts 0..DIV-1 and wraps to 0.
  - tick is registered high in the cycle after the prescaler equals DIV-1, so there is exactly one pulse per DIV cycles.
  - First tick after reset release arrives at cycle DIV.
- sel: on tick, sel <= (sel == N_DIGITS-1) ? 0 : sel+1. With N_DIGITS = 1, sel stays 0.
- Output register (1-cycle latency):
  - Every cycle, seg <= decode(digito) and an <= active-low one-hot of sel, so seg and an always describe the same position.
  - Because digito follows sel combinationally, seg/an reflect the sel value of the previous cycle.
- Decode, active-low:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - 10..15 = 1111111 (blank; never produced upstream but defined)
- Enable: en = 0 forces an <= 4'b1111 next cycle; seg still decodes, and prescaler and sel still advance.
- Reset mid-scan: all state returns to reset values the next edge; no partial tick is emitted.
- Invalid digit positions: an[i] is held at 1 for i >= N_DIGITS regardless of sel.

Optional Feature:
- Macro: DISPLAY_MUX_BLANK_EN.
- Defined:
  - A blank counter loads BLANK_CYCLES on each tick and decrements to 0.
  - While it is nonzero, an <= 4'b1111, giving an anti-ghosting gap.
  - seg and sel timing are unchanged.
- Undefined: no counter logic is synthesised; anodes switch in the cycle after sel changes.

Decomposition:
- Shared package (display_pkg) holds:
  - segment pattern constants SEG_0..SEG_9 and SEG_BLANK
  - AN_OFF = 4'b1111
  - localparam function for DIV
- One sub-module: seg7_decode, a pure combinational 4-bit to 7-bit active-low decoder, reused by later display blocks.
- Prescaler, sel counter, blanking and output register stay in the top module.

Test Plan (CLK_HZ=100, REFRESH_HZ=10 so DIV=10, N_DIGITS=2, BLANK_CYCLES=3, bench models the BCD stage with bin=13):
- Reset release: an = 1111, seg = 1111111 until first update, then an = 1110 and seg = SEG_3 (0110000); tick first high at cycle 10.
- Scan: tick every 10 cycles; sel alternates 0,1,0; an alternates 1110/1101 one cycle after each sel change; seg alternates SEG_3/SEG_1 (1111001).
- N_DIGITS=1: sel stuck at 0, an constant 1110; N_DIGITS=4 with digito=8 gives an cycling 1110, 1101, 1011, 0111, then 1110 again, seg = 0000000.
- en=0 for 25 cycles mid-scan: an = 1111 from the next cycle; sel still advances on each tick; an resumes the correct position one cycle after en=1.
- rst asserted 4 cycles after a tick: next cycle sel = 0, an = 1111, tick = 0; next tick occurs 10 cycles after rst deassert.
- DISPLAY_MUX_BLANK_EN defined: an = 1111 for 3 cycles after every tick, then shows the new position; undefined: no blank gap, and digito = 12 gives seg = 1111111.
